serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder.
- Loads two N-bit operands and a carry-in on a start request.
- Each cycle, feeds one bit pair plus the registered carry through a single one-bit full adder, LSB first.
- Presents the N-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of the one-bit full adder. It is the sequential stage that drives that adder and consumes its sum and carry outputs, trading area for N cycles of latency.

Parameters:
- N, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  N  operand A; captured on the accepted start edge
- b  input  N  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; result is valid from this cycle onward
- sum  output  N  registered result; holds until the next result edge
- cout  output  1  registered final carry; holds with sum

Behaviour:
- Reset state: IDLE; busy=0, done=0, sum=0, cout=0.
- Reset clears all internal state: shift registers, carry, counter.
- rst has priority over every other input on the same edge.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1 at edge E0:
  - load shift registers A<=a, B<=b;
  - carry<=cin, bit count<=0, accumulator<=0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - full-adder inputs are A[0], B[0] and carry;
  - A and B shift right by one;
  - the adder sum bit shifts into the accumulator MSB, and the accumulator shifts right;
  - carry<=adder carry, count<=count+1.
- RUN, edge where count==N-1 (edge E_N):
  - the last bit is processed;
  - sum<=final accumulator value, cout<=final adder carry;
  - go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE, where done=0.
- Latency: done is high in the cycle following E_N, i.e. N+1 edges after the start edge.
- Throughput: one addition per N+2 cycles when start is held high.
- Operand stability: a, b and cin are don't-care after E0. Changes during RUN must not affect the result.
- start while busy (RUN or DONE) is ignored; no queuing.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Output stability: sum and cout change only at E_N of an operation or on reset. Partial accumulator values are never visible on sum.
- Reset mid-RUN: the next edge returns to IDLE with all outputs 0. The aborted operation produces no done pulse.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(N+1); no overflow flag.
- Counter width: clog2(N) bits. Counting stops at N-1, so there is no wrap-around.

Decomposition:
- Shared package serial_adder_pkg holds:
  - enumerated state type state_t, with IDLE/RUN/DONE;
  - helper constant CNT_W = $clog2(N), or an equivalent function.
- One sub-module: instantiate the existing fulladder for the per-bit add (ain, bin, cin -> cout, sout). No other hierarchy.

Test Plan:
- N=8, a=8'h35, b=8'h4A, cin=0, start pulsed one cycle -> busy high for 9 cycles, done high on the 9th edge after start, sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Accept a=8'h10, b=8'h20, then change a/b/cin and pulse start every cycle during RUN -> exactly one done, sum=8'h30, and no second operation starts until after DONE.
- Load a=8'hAA, b=8'h55, assert rst on the 4th RUN edge -> next cycle state IDLE, busy=0, sum=0, cout=0, and no done pulse ever follows.
- start held high for 3 back-to-back operations with (1+1), (8'h80+8'h80), (8'h7F+8'h01, cin=1) -> results 8'h02/0, 8'h00/1, 8'h81/0, with done pulses spaced 10 cycles apart (N+2).
- Randomised sweep, N=8 and N=4, 500 operand triples -> {cout,sum} matches the a+b+cin reference model every time, and sum stays stable between done pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    // Controller states: waiting for work, shifting bits, presenting result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for an n-bit operation; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module fulladder (
    input  logic ain,
    input  logic bin,
    input  logic cin,
    output logic cout,
    output logic sout
);

    assign sout = ain ^ bin ^ cin;
    assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full adder, LSB first, N cycles per add.
// Legal N range is 2..32.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [N-1:0]       acc_q, acc_d;
    logic [N-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fa_sum, fa_carry;

    // The current LSBs of the operand shifters plus the running carry.
    fulladder u_fa (
        .ain  (a_q[0]),
        .bin  (b_q[0]),
        .cin  (carry_q),
        .cout (fa_carry),
        .sout (fa_sum)
    );

    // Next-state and datapath: load on start, shift in RUN, publish at the last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[N-1:1]};
                b_d     = {1'b0, b_q[N-1:1]};
                acc_d   = {fa_sum, acc_q[N-1:1]};
                carry_d = fa_carry;
                if (cnt_q == LAST) begin
                    // Counter holds at N-1; result goes straight to the output regs.
                    sum_d   = {fa_sum, acc_q[N-1:1]};
                    cout_d  = fa_carry;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset wins over everything on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
